// File: rtl/sd_out_pio_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a hardware-timed one-shot pulse
// that inverts masked output bits for LEN clocks, with sticky DONE/OVR flags and irq.
module sd_out_pio_pulse #(
  parameter int unsigned WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_irq_en;
  logic             r_done;
  logic             r_ovr;

  logic             w_wr;
  logic             w_busy;
  logic             w_pulse_wr;
  logic             w_pulse_end;
  logic             w_clr_done;
  logic             w_clr_ovr;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_irq_en_nxt;
  logic             w_done_nxt;
  logic             w_ovr_nxt;
  logic [31:0]      w_rd;

  assign w_wr        = chipselect & ~write_n;
  assign w_busy      = (r_state == ST_ACTIVE);
  assign w_pulse_end = w_busy & (r_cnt == CNT_W'(1));

  // Register write decode and next values of the sticky flags (a set beats a clear).
  always_comb begin
    w_data_nxt   = r_data;
    w_irq_en_nxt = r_irq_en;
    w_pulse_wr   = 1'b0;
    w_clr_done   = 1'b0;
    w_clr_ovr    = 1'b0;
    if (w_wr) begin
      case (address)
        3'd0:    w_data_nxt   = writedata[WIDTH-1:0];
        3'd1:    w_irq_en_nxt = writedata[0];
        3'd3: begin
          w_clr_done = writedata[1];
          w_clr_ovr  = writedata[2];
        end
        3'd4:    w_data_nxt   = r_data | writedata[WIDTH-1:0];
        3'd5:    w_data_nxt   = r_data & ~writedata[WIDTH-1:0];
        3'd6:    w_pulse_wr   = 1'b1;
        default: w_data_nxt   = r_data;
      endcase
    end else begin
      w_data_nxt = r_data;
    end
    w_done_nxt = w_pulse_end | (r_done & ~w_clr_done);
    w_ovr_nxt  = (w_pulse_wr & w_busy) | (r_ovr & ~w_clr_ovr);
  end

  // Read mux; upper bits of every field read as zero.
  always_comb begin
    w_rd = 32'd0;
    case (address)
      3'd0:    w_rd[WIDTH-1:0] = r_data;
      3'd1:    w_rd[0]         = r_irq_en;
      3'd2:    w_rd[CNT_W-1:0] = r_len;
      3'd3:    w_rd[2:0]       = {r_ovr, r_done, w_busy};
      3'd6:    w_rd[WIDTH-1:0] = r_mask;
      default: w_rd            = 32'd0;
    endcase
  end

  // Registers, pulse FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_data   <= RST_DATA;
      r_mask   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      out_port <= RST_DATA;
      readdata <= 32'd0;
      irq      <= 1'b0;
    end else begin
      r_data   <= w_data_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_done   <= w_done_nxt;
      r_ovr    <= w_ovr_nxt;
      out_port <= r_data ^ (r_mask & {WIDTH{w_busy}});
      readdata <= w_rd;
      irq      <= w_done_nxt & w_irq_en_nxt;
      if (w_wr && (address == 3'd2)) begin
        r_len <= writedata[CNT_W-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pulse_wr) begin
            r_mask <= writedata[WIDTH-1:0];
            // A zero length only loads the mask.
            if (r_len != '0) begin
              r_cnt   <= r_len;
              r_state <= ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_out_pio_pulse.sv
// Scoreboard bench for sd_out_pio_pulse: a cycle-level reference model pushes expected
// out_port/readdata/irq per clock edge; a negedge monitor pops and compares.
module tb_sd_out_pio_pulse;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;
  localparam logic [W-1:0] RV = 4'hA;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
  logic          irq;

  always #5 clk = ~clk;

  sd_out_pio_pulse #(.WIDTH(W), .RESET_VALUE(32'hA), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  typedef struct {
    int unsigned  edge_n;
    logic [W-1:0] out;
    logic [31:0]  rd;
    logic         irq;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned tb_edges = 0;

  always @(posedge clk) tb_edges <= tb_edges + 1;

  // Reference model state: a pulse is "active" until the edge number m_end.
  logic [W-1:0]  m_data, m_mask;
  logic [CW-1:0] m_len;
  logic          m_irq_en, m_done, m_ovr, m_active;
  int unsigned   m_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int unsigned e);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s edge=%0d got=0x%0h expected=0x%0h", name, e, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].edge_n <= tb_edges) begin
      exp_t x;
      x = q.pop_front();
      chk("out_port", 32'(out_port), 32'(x.out), x.edge_n);
      chk("readdata", readdata, x.rd, x.edge_n);
      chk("irq", 32'(irq), 32'(x.irq), x.edge_n);
    end
  end

  task automatic step(input logic rst, input logic wr, input logic [2:0] a, input logic [31:0] d);
    exp_t        x;
    int unsigned e;
    logic        busy, ending, clr_d, clr_o;
    @(negedge clk);
    reset     = rst;
    address   = a;
    writedata = d;
    if (wr) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
    end else begin
      chipselect = 1'($urandom_range(0, 1));
      write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
    end
    e = tb_edges + 1;
    x.edge_n = e;
    if (rst) begin
      m_data = RV; m_mask = '0; m_len = '0; m_irq_en = 1'b0;
      m_done = 1'b0; m_ovr = 1'b0; m_active = 1'b0; m_end = 0;
      x.out = RV; x.rd = 32'd0; x.irq = 1'b0;
    end else begin
      busy   = m_active;
      ending = m_active && (e == m_end);
      x.out  = m_data ^ (busy ? m_mask : 4'h0);
      case (a)
        3'd0:    x.rd = 32'(m_data);
        3'd1:    x.rd = 32'(m_irq_en);
        3'd2:    x.rd = 32'(m_len);
        3'd3:    x.rd = {29'd0, m_ovr, m_done, busy};
        3'd6:    x.rd = 32'(m_mask);
        default: x.rd = 32'd0;
      endcase
      clr_d = wr && a == 3'd3 && d[1];
      clr_o = wr && a == 3'd3 && d[2];
      m_done = ending | (m_done & ~clr_d);
      m_ovr  = (wr && a == 3'd6 && busy) | (m_ovr & ~clr_o);
      if (ending) m_active = 1'b0;
      if (wr) begin
        case (a)
          3'd0: m_data = d[W-1:0];
          3'd1: m_irq_en = d[0];
          3'd2: m_len = d[CW-1:0];
          3'd4: m_data = m_data | d[W-1:0];
          3'd5: m_data = m_data & ~d[W-1:0];
          3'd6: if (!busy) begin
            m_mask = d[W-1:0];
            if (m_len != 0) begin
              m_active = 1'b1;
              m_end    = e + m_len;
            end
          end
          default: ;
        endcase
      end
      x.irq = m_done & m_irq_en;
    end
    q.push_back(x);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    // reset, then read DATA
    step(1'b1, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b0, 3'd0, 32'd0);
    step(1'b0, 1'b0, 3'd0, 32'd0);
    idle(2);
    // set / clear
    wr(3'd0, 32'h3); wr(3'd4, 32'h8); wr(3'd5, 32'h1);
    step(1'b0, 1'b0, 3'd0, 32'd0);
    idle(2);
    // basic pulse with irq, then clear DONE
    wr(3'd0, 32'h0); wr(3'd2, 32'd5); wr(3'd1, 32'h1); wr(3'd6, 32'h6);
    idle(7);
    wr(3'd3, 32'h2);
    idle(2);
    // LEN = 0 pulse, then overrun
    wr(3'd2, 32'h0); wr(3'd6, 32'h5); idle(2);
    step(1'b0, 1'b0, 3'd6, 32'd0);
    wr(3'd2, 32'd10); wr(3'd6, 32'h1); idle(1); wr(3'd6, 32'hF);
    step(1'b0, 1'b0, 3'd6, 32'd0);
    idle(12);
    step(1'b0, 1'b0, 3'd3, 32'd0);
    wr(3'd3, 32'h6);
    // mid-pulse edit
    wr(3'd0, 32'h0); wr(3'd2, 32'd8); wr(3'd6, 32'h1); idle(1); wr(3'd4, 32'h2);
    idle(10);
    // DONE set and STATUS clear on the same edge
    wr(3'd2, 32'd3); wr(3'd6, 32'h1);
    step(1'b0, 1'b0, 3'd3, 32'd0);
    step(1'b0, 1'b0, 3'd3, 32'd0);
    wr(3'd3, 32'h6);
    step(1'b0, 1'b0, 3'd3, 32'd0);
    // reset mid-pulse
    wr(3'd1, 32'h1); wr(3'd2, 32'd100); wr(3'd6, 32'hF);
    idle(19);
    step(1'b1, 1'b0, 3'd3, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd3, 32'd0);
    // maximum length
    wr(3'd2, 32'd255); wr(3'd6, 32'h3);
    idle(260);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [2:0]  a;
      r = $urandom_range(0, 99);
      a = 3'($urandom_range(0, 7));
      if (r < 2) step(1'b1, 1'b0, a, $urandom);
      else if (r < 40) wr(a, (a == 3'd2) ? 32'($urandom_range(0, 12)) : $urandom);
      else step(1'b0, 1'b0, a, $urandom);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_out_pio_pulse.md
Name: sd_out_pio_pulse

Overview:
- Avalon-MM slave output PIO: the write-side counterpart of the system's single-bit input PIO.
- Drives a WIDTH-bit out_port to board-level SD/LED/control lines.
- Supports atomic set/clear, and a hardware-timed one-shot pulse that inverts masked bits for a programmed number of clocks, then restores them.
- Sits on the Nios II data master interconnect; optional irq to the CPU when a pulse completes.

Parameters:
WIDTH, 4, number of output bits (1..32)
RESET_VALUE, 0, out_port and DATA value after reset
CNT_W, 16, pulse length counter width (1..32)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
address  in  3  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe; write accepted when chipselect=1 and write_n=0
writedata  in  32  write data
readdata  out  32  registered read data
out_port  out  WIDTH  registered output pins
irq  out  1  level interrupt = DONE and IRQ_EN

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: reset sampled high at a rising edge forces all registers to reset values at that edge.
  - Reset values: DATA=RESET_VALUE, out_port=RESET_VALUE, readdata=0, IRQ_EN=0, LEN=0, MASK=0, counter=0, state=IDLE, DONE=0, OVR=0, irq=0.
- Register map (writedata/readdata bits above the field width: ignored on write, zero on read):
  - 0 DATA: RW, WIDTH bits.
  - 1 CTRL: RW, bit0 IRQ_EN.
  - 2 LEN: RW, CNT_W bits, pulse length in clocks.
  - 3 STATUS: read {29'b0, OVR, DONE, BUSY}. Write: each 1 in bits[2:1] clears that sticky flag.
  - 4 OUTSET: write-only. DATA <= DATA | writedata[WIDTH-1:0]. Reads 0.
  - 5 OUTCLR: write-only. DATA <= DATA & ~writedata[WIDTH-1:0]. Reads 0.
  - 6 PULSE: write starts a pulse with MASK <= writedata[WIDTH-1:0]. Reads current MASK.
  - 7: reserved; writes ignored, reads 0.
- Read path:
  - readdata <= mux(address) on every clock, with no read strobe.
  - Data appears 1 cycle after address is presented.
  - Reads have no side effects.
- Write timing: a write accepted at edge k updates its register at edge k.
- Output:
  - out_port <= DATA ^ (MASK & {WIDTH{BUSY}}) each clock.
  - out_port therefore reflects register changes 1 cycle later (edge k+1).
  - Glitch-free, since out_port is a register.
- Pulse FSM, states IDLE and ACTIVE:
  - IDLE, PULSE write, LEN != 0: load MASK, set counter to LEN, go to ACTIVE (BUSY=1 from edge k).
  - IDLE, PULSE write, LEN == 0: MASK is loaded; no state change and no DONE.
  - ACTIVE: counter decrements every clock.
  - ACTIVE, counter==1 at an edge: go to IDLE, counter=0, DONE<=1.
  - Net effect: BUSY is high for exactly LEN clocks, and masked out_port bits are inverted for exactly LEN clocks, shifted 1 cycle later.
  - ACTIVE, PULSE write: ignored (MASK and counter unchanged); OVR<=1.
- DATA, OUTSET or OUTCLR writes during ACTIVE: allowed; out_port = new DATA ^ MASK.
- LEN write during ACTIVE: stored, used by the next pulse only.
- DONE set and a STATUS clear on the same edge: set wins (DONE stays 1). Same rule for OVR.
- Counter at maximum (LEN = 2^CNT_W-1): no wrap; pulse lasts the full count.
- Reset mid-pulse: FSM to IDLE, flags cleared, out_port=RESET_VALUE at the reset edge; no DONE is generated.
- Throughput: at most one write per clock (single address bus), so there is no simultaneous-write arbitration.

Test Plan:
- Reset: assert reset 2 cycles with RESET_VALUE=4'hA -> out_port=4'hA, readdata=0, irq=0. Read addr 0 -> 0x0000000A one cycle later.
- Set/clear: write DATA=4'h3, OUTSET 4'h8, OUTCLR 4'h1 on consecutive cycles -> out_port sequence 3, B, A, each one cycle after its write. Read DATA -> 0xA.
- Pulse: DATA=0, LEN=5, IRQ_EN=1, PULSE 4'h6 at edge k -> BUSY=1 edges k..k+4, out_port=6 for edges k+1..k+5 then 0. DONE=1 and irq=1 from edge k+5. Write STATUS 0x2 -> irq=0.
- Overrun/LEN=0: PULSE with LEN=0 -> out_port unchanged, DONE=0. LEN=10, PULSE 4'h1, then PULSE 4'hF at cycle 3 -> OVR=1, MASK reads 0x1, pulse ends after 10 clocks.
- Mid-pulse edits: LEN=8, PULSE 4'h1, OUTSET 4'h2 at cycle 2 -> out_port=3 while active, then 2 after completion. Simultaneous DONE set and STATUS clear -> DONE reads 1.
- Reset mid-pulse: LEN=100, PULSE 4'hF, reset at cycle 20 -> out_port=RESET_VALUE at reset edge, BUSY=0, DONE=0, irq never asserted.
